store_buffer: RTL and testbench

//   Posted-write buffer between the single-cycle CPU datapath and the data memory.

---
 rtl/store_buffer_if.sv | 31 +++
 rtl/store_buffer.sv | 88 ++++++++
 tb/tb_store_buffer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// CPU/memory-side signal bundle for the store buffer. The master modport is the
// CPU plus data memory environment; the slave modport is the store buffer itself.
interface store_buffer_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_store_valid;
    logic          cpu_store_ready;
    logic          cpu_load_valid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_load_data;
    logic          cpu_load_stall;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_en;
    logic [DW-1:0] mem_read_data;
    logic          buf_empty;

    modport master (
        output cpu_store_valid, cpu_load_valid, cpu_addr, cpu_wdata, mem_read_data,
        input  cpu_store_ready, cpu_load_data, cpu_load_stall,
               mem_address, mem_write_data, mem_write_en, buf_empty
    );

    modport slave (
        input  cpu_store_valid, cpu_load_valid, cpu_addr, cpu_wdata, mem_read_data,
        output cpu_store_ready, cpu_load_data, cpu_load_stall,
               mem_address, mem_write_data, mem_write_en, buf_empty
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the CPU and data memory; drains one store per idle cycle.
// Define STORE_BUF_FWD_EN to forward the youngest matching store to loads instead of stalling.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input logic         clk,
    input logic         rst_n,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];

    logic          w_hit;
    logic          w_drain;
    logic          w_full;
    logic          w_push;
`ifdef STORE_BUF_FWD_EN
    logic [DW-1:0] w_fwd_data;
`endif

    // Scan oldest to youngest so the last match found is the youngest store.
    always_comb begin
        w_hit = 1'b0;
`ifdef STORE_BUF_FWD_EN
        w_fwd_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (r_addr[r_rd_ptr + PW'(i)] == bus.cpu_addr)) begin
                w_hit = 1'b1;
`ifdef STORE_BUF_FWD_EN
                w_fwd_data = r_data[r_rd_ptr + PW'(i)];
`endif
            end
        end
    end

`ifdef STORE_BUF_FWD_EN
    assign w_drain            = (r_count != '0) & ~bus.cpu_load_valid;
    assign bus.mem_address    = bus.cpu_load_valid ? bus.cpu_addr : r_addr[r_rd_ptr];
    assign bus.cpu_load_stall = 1'b0;
    assign bus.cpu_load_data  = w_hit ? w_fwd_data : bus.mem_read_data;
`else
    // A stalled (hitting) load leaves the port to the drain so the hit can clear.
    assign w_drain            = (r_count != '0) & (~bus.cpu_load_valid | w_hit);
    assign bus.mem_address    = (bus.cpu_load_valid & ~w_hit) ? bus.cpu_addr : r_addr[r_rd_ptr];
    assign bus.cpu_load_stall = bus.cpu_load_valid & w_hit;
    assign bus.cpu_load_data  = bus.mem_read_data;
`endif

    assign w_full              = (r_count == CW'(DEPTH));
    assign bus.cpu_store_ready = ~bus.cpu_load_valid & (~w_full | w_drain);
    assign w_push              = bus.cpu_store_valid & bus.cpu_store_ready;
    assign bus.mem_write_en    = w_drain;
    assign bus.mem_write_data  = r_data[r_rd_ptr];
    assign bus.buf_empty       = (r_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_drain) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push)  r_wr_ptr <= r_wr_ptr + PW'(1);
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload carries no reset; validity is defined by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= bus.cpu_addr;
            r_data[r_wr_ptr] <= bus.cpu_wdata;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with a negedge-write data memory model.
// Expectations follow STORE_BUF_FWD_EN when the bench is built with it defined.
module tb_store_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    store_buffer_if #(.AW(16), .DW(16)) bus ();
    store_buffer #(.DEPTH(4), .AW(16), .DW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    // Memory model: unwritten words read as {8'hA5, addr[7:0]}.
    logic [15:0] mem [256];
    bit          wr  [256];
    logic [15:0] wq_a [$];
    logic [15:0] wq_d [$];
    logic [7:0]  ra;
    assign ra = bus.mem_address[7:0];
    assign bus.mem_read_data = wr[ra] ? mem[ra] : {8'hA5, ra};

    always @(negedge clk) begin
        if (bus.mem_write_en) begin
            mem[bus.mem_address[7:0]] <= bus.mem_write_data;
            wr[bus.mem_address[7:0]]  <= 1'b1;
            wq_a.push_back(bus.mem_address);
            wq_d.push_back(bus.mem_write_data);
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic mid();  @(negedge clk); #1; endtask

    task automatic drive(input logic sv, input logic lv, input logic [15:0] a, input logic [15:0] d);
        bus.cpu_store_valid = sv; bus.cpu_load_valid = lv; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic test_reset();
        drive(0, 0, 16'h0, 16'h0);
        rst_n = 1'b0;
        #3;
        checks++; if (bus.buf_empty !== 1'b1)       begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.buf_empty); end
        checks++; if (bus.cpu_store_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.cpu_store_ready); end
        checks++; if (bus.mem_write_en !== 1'b0)    begin failures++; $display("FAIL reset_wen got=%b exp=0", bus.mem_write_en); end
        checks++; if (bus.cpu_load_stall !== 1'b0)  begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.cpu_load_stall); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fifo_drain();
        logic [15:0] ea [3] = '{16'h010, 16'h011, 16'h012};
        logic [15:0] ed [3] = '{16'h1111, 16'h2222, 16'h3333};
        wq_a.delete(); wq_d.delete();
        drive(1, 0, 16'h010, 16'h1111); mid();
        checks++; if (bus.cpu_store_ready !== 1'b1) begin failures++; $display("FAIL drain_ready0 got=%b exp=1", bus.cpu_store_ready); end
        checks++; if (bus.mem_write_en !== 1'b0)    begin failures++; $display("FAIL drain_wen0 got=%b exp=0", bus.mem_write_en); end
        tick();
        drive(1, 0, 16'h011, 16'h2222); mid();
        checks++; if (bus.mem_write_en !== 1'b1 || bus.mem_address !== 16'h010) begin failures++; $display("FAIL drain_c1 wen=%b addr=%h exp wen=1 addr=0010", bus.mem_write_en, bus.mem_address); end
        tick();
        drive(1, 0, 16'h012, 16'h3333); tick();
        drive(0, 0, 16'h0, 16'h0); mid();
        checks++; if (bus.mem_write_en !== 1'b1 || bus.mem_address !== 16'h012 || bus.mem_write_data !== 16'h3333)
            begin failures++; $display("FAIL drain_c3 wen=%b addr=%h data=%h exp 1/0012/3333", bus.mem_write_en, bus.mem_address, bus.mem_write_data); end
        checks++; if (bus.buf_empty !== 1'b0) begin failures++; $display("FAIL drain_notempty got=%b exp=0", bus.buf_empty); end
        tick(); mid();
        checks++; if (bus.buf_empty !== 1'b1 || bus.mem_write_en !== 1'b0) begin failures++; $display("FAIL drain_done empty=%b wen=%b exp 1/0", bus.buf_empty, bus.mem_write_en); end
        checks++; if (wq_a.size() !== 3) begin failures++; $display("FAIL drain_count got=%0d exp=3", wq_a.size()); end
        for (int i = 0; i < 3 && i < wq_a.size(); i++) begin
            checks++; if (wq_a[i] !== ea[i] || wq_d[i] !== ed[i]) begin failures++; $display("FAIL drain_order%0d got=%h/%h exp=%h/%h", i, wq_a[i], wq_d[i], ea[i], ed[i]); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        wq_a.delete(); wq_d.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 16'h040 + 16'(i), 16'hC000 + 16'(i)); mid();
            checks++; if (bus.cpu_store_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", i, bus.cpu_store_ready); end
            checks++; if (bus.mem_write_en !== (i != 0)) begin failures++; $display("FAIL b2b_wen%0d got=%b exp=%b", i, bus.mem_write_en, (i != 0)); end
            tick();
        end
        drive(0, 0, 16'h0, 16'h0); mid();
        checks++; if (bus.buf_empty !== 1'b0 || bus.mem_address !== 16'h044) begin failures++; $display("FAIL b2b_last empty=%b addr=%h exp 0/0044", bus.buf_empty, bus.mem_address); end
        tick(); mid();
        checks++; if (bus.buf_empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", bus.buf_empty); end
        checks++; if (wq_a.size() !== 5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", wq_a.size()); end
        for (int i = 0; i < 5 && i < wq_a.size(); i++) begin
            checks++; if (wq_a[i] !== 16'h040 + 16'(i) || wq_d[i] !== 16'hC000 + 16'(i))
                begin failures++; $display("FAIL b2b_order%0d got=%h/%h exp=%h/%h", i, wq_a[i], wq_d[i], 16'h040 + 16'(i), 16'hC000 + 16'(i)); end
        end
        tick();
    endtask

    task automatic test_load_miss();
        drive(1, 0, 16'h050, 16'h5555); tick();
        drive(0, 1, 16'h030, 16'h0); mid();
        checks++; if (bus.mem_address !== 16'h030 || bus.mem_write_en !== 1'b0) begin failures++; $display("FAIL miss_port addr=%h wen=%b exp 0030/0", bus.mem_address, bus.mem_write_en); end
        checks++; if (bus.cpu_load_stall !== 1'b0 || bus.cpu_load_data !== 16'hA530) begin failures++; $display("FAIL miss_data stall=%b data=%h exp 0/A530", bus.cpu_load_stall, bus.cpu_load_data); end
        checks++; if (bus.cpu_store_ready !== 1'b0) begin failures++; $display("FAIL miss_ready got=%b exp=0", bus.cpu_store_ready); end
        tick();
        drive(0, 0, 16'h0, 16'h0); mid();
        checks++; if (bus.buf_empty !== 1'b0 || bus.mem_write_en !== 1'b1 || bus.mem_address !== 16'h050)
            begin failures++; $display("FAIL miss_resume empty=%b wen=%b addr=%h exp 0/1/0050", bus.buf_empty, bus.mem_write_en, bus.mem_address); end
        tick();
        // Same low bits, different upper bits: must not count as a hit.
        drive(1, 0, 16'h1020, 16'h7777); tick();
        drive(0, 1, 16'h0020, 16'h0); mid();
        checks++; if (bus.cpu_load_stall !== 1'b0 || bus.mem_address !== 16'h0020 || bus.mem_write_en !== 1'b0 || bus.cpu_load_data !== 16'hA520)
            begin failures++; $display("FAIL fullaw stall=%b addr=%h wen=%b data=%h exp 0/0020/0/A520", bus.cpu_load_stall, bus.mem_address, bus.mem_write_en, bus.cpu_load_data); end
        tick();
        drive(0, 0, 16'h0, 16'h0); tick(); tick();
    endtask

    task automatic test_forward();
        drive(1, 0, 16'h020, 16'h1234); tick();
        drive(1, 0, 16'h020, 16'hBEEF); tick();
        drive(0, 1, 16'h020, 16'h0); mid();
`ifdef STORE_BUF_FWD_EN
        checks++; if (bus.cpu_load_data !== 16'hBEEF || bus.cpu_load_stall !== 1'b0) begin failures++; $display("FAIL fwd_hit data=%h stall=%b exp BEEF/0", bus.cpu_load_data, bus.cpu_load_stall); end
        checks++; if (bus.mem_write_en !== 1'b0) begin failures++; $display("FAIL fwd_nodrain got=%b exp=0", bus.mem_write_en); end
        tick();
        drive(0, 0, 16'h0, 16'h0); mid();
        checks++; if (bus.mem_write_en !== 1'b1 || bus.mem_write_data !== 16'hBEEF) begin failures++; $display("FAIL fwd_drain wen=%b data=%h exp 1/BEEF", bus.mem_write_en, bus.mem_write_data); end
        tick();
`else
        checks++; if (bus.cpu_load_stall !== 1'b1) begin failures++; $display("FAIL hit_stall got=%b exp=1", bus.cpu_load_stall); end
        checks++; if (bus.mem_write_en !== 1'b1 || bus.mem_address !== 16'h020 || bus.mem_write_data !== 16'hBEEF)
            begin failures++; $display("FAIL hit_drain wen=%b addr=%h data=%h exp 1/0020/BEEF", bus.mem_write_en, bus.mem_address, bus.mem_write_data); end
        tick(); mid();
        checks++; if (bus.cpu_load_stall !== 1'b0 || bus.cpu_load_data !== 16'hBEEF || bus.mem_write_en !== 1'b0)
            begin failures++; $display("FAIL hit_release stall=%b data=%h wen=%b exp 0/BEEF/0", bus.cpu_load_stall, bus.cpu_load_data, bus.mem_write_en); end
        tick();
        drive(0, 0, 16'h0, 16'h0);
`endif
        mid();
        checks++; if (bus.buf_empty !== 1'b1) begin failures++; $display("FAIL fwd_empty got=%b exp=1", bus.buf_empty); end
        tick();
    endtask

    task automatic test_conflict();
        wq_a.delete(); wq_d.delete();
        drive(1, 1, 16'h060, 16'h6666); mid();
        checks++; if (bus.cpu_store_ready !== 1'b0) begin failures++; $display("FAIL conf0_ready got=%b exp=0", bus.cpu_store_ready); end
        tick();
        drive(0, 0, 16'h0, 16'h0); mid();
        checks++; if (bus.buf_empty !== 1'b1) begin failures++; $display("FAIL conf0_empty got=%b exp=1", bus.buf_empty); end
        tick();
        drive(1, 0, 16'h061, 16'hAAAA); tick();
        drive(1, 1, 16'h062, 16'hBBBB); mid();
        checks++; if (bus.cpu_store_ready !== 1'b0) begin failures++; $display("FAIL conf1_ready got=%b exp=0", bus.cpu_store_ready); end
        tick();
        drive(0, 0, 16'h0, 16'h0); tick(); mid();
        checks++; if (bus.buf_empty !== 1'b1 || bus.mem_write_en !== 1'b0) begin failures++; $display("FAIL conf1_count empty=%b wen=%b exp 1/0", bus.buf_empty, bus.mem_write_en); end
        checks++; if (wq_a.size() !== 1 || (wq_a.size() > 0 && wq_a[0] !== 16'h061)) begin failures++; $display("FAIL conf_writes n=%0d exp one write to 0061", wq_a.size()); end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        int n;
        drive(1, 0, 16'h070, 16'h7070); tick();
        drive(1, 0, 16'h071, 16'h7171); #2;
        checks++; if (bus.mem_write_en !== 1'b1) begin failures++; $display("FAIL rst_predrain got=%b exp=1", bus.mem_write_en); end
        n = wq_a.size();
        drive(0, 0, 16'h0, 16'h0);
        rst_n = 1'b0; #1;
        checks++; if (bus.mem_write_en !== 1'b0 || bus.buf_empty !== 1'b1 || bus.cpu_store_ready !== 1'b1 || bus.cpu_load_stall !== 1'b0)
            begin failures++; $display("FAIL rst_async wen=%b empty=%b ready=%b stall=%b exp 0/1/1/0", bus.mem_write_en, bus.buf_empty, bus.cpu_store_ready, bus.cpu_load_stall); end
        mid();
        checks++; if (wq_a.size() !== n) begin failures++; $display("FAIL rst_abort writes=%0d exp=%0d", wq_a.size(), n); end
        tick();
        rst_n = 1'b1;
        tick(); mid();
        checks++; if (bus.buf_empty !== 1'b1 || bus.mem_write_en !== 1'b0 || wq_a.size() !== n)
            begin failures++; $display("FAIL rst_after empty=%b wen=%b writes=%0d exp 1/0/%0d", bus.buf_empty, bus.mem_write_en, wq_a.size(), n); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 16'h0, 16'h0);
        test_reset();
        test_fifo_drain();
        test_back_to_back();
        test_load_miss();
        test_forward();
        test_conflict();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
